instr_encoder_loader: RTL and testbench

//  Encodes LEGv8 instruction requests (op + register fields + immediate) into 32-bit words and

---
 rtl/instr_encoder_loader_if.sv | 25 ++
 rtl/instr_encoder_loader.sv | 106 ++++++++++
 tb/tb_instr_encoder_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write channels of the LEGv8 program loader.
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rn;
  logic [4:0]  req_rm;
  logic [25:0] req_imm;
  logic [1:0]  req_hw;
  logic        imem_we;
  logic        imem_wready;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw, imem_wready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_hw, imem_wready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8 instruction requests into 32-bit words and streams them into imem
// at sequential addresses, one held word at a time, until DEPTH words are written.
module instr_encoder_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                          CLK,
  input  logic                          resetl,
  input  logic                          clear,
  instr_encoder_loader_if.slave         bus,
  output logic                          err,
  output logic [15:0]                   word_count,
  output logic                          full
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FULL} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      r_state, w_next;
  logic [63:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_count;
  logic        r_err;

  logic        w_legal;
  logic [31:0] w_enc;
  logic        w_ready;
  logic        w_accept;
  logic        w_done;
  logic        w_last;

  always_comb begin
    w_legal = 1'b1;
    w_enc   = '0;
    case (bus.req_op)
      4'd0:  w_enc = {11'b10001010000, bus.req_rm, 6'b0, bus.req_rn, bus.req_rd};
      4'd1:  w_enc = {11'b10101010000, bus.req_rm, 6'b0, bus.req_rn, bus.req_rd};
      4'd2:  w_enc = {11'b10001011000, bus.req_rm, 6'b0, bus.req_rn, bus.req_rd};
      4'd3:  w_enc = {11'b11001011000, bus.req_rm, 6'b0, bus.req_rn, bus.req_rd};
      4'd4:  w_enc = {10'b1001000100, bus.req_imm[11:0], bus.req_rn, bus.req_rd};
      4'd5:  w_enc = {10'b1101000100, bus.req_imm[11:0], bus.req_rn, bus.req_rd};
      4'd6:  w_enc = {9'b110100101, bus.req_hw, bus.req_imm[15:0], bus.req_rd};
      4'd7:  w_enc = {6'b000101, bus.req_imm[25:0]};
      4'd8:  w_enc = {8'b10110100, bus.req_imm[18:0], bus.req_rd};
      4'd9:  w_enc = {11'b11111000010, bus.req_imm[8:0], 2'b00, bus.req_rn, bus.req_rd};
      4'd10: w_enc = {11'b11111000000, bus.req_imm[8:0], 2'b00, bus.req_rn, bus.req_rd};
      default: w_legal = 1'b0;
    endcase
  end

  // The completing word that fills the memory must not let a new request in,
  // and clear blocks the handshake so a request during clear is held, not lost.
  assign w_done   = (r_state == S_HOLD) && bus.imem_wready;
  assign w_last   = (({1'b0, r_count} + 17'd1) == DEPTH_W);
  assign w_ready  = !clear && ((r_state == S_IDLE) || (w_done && !w_last));
  assign w_accept = bus.req_valid && w_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_legal) w_next = S_HOLD;
      S_HOLD: begin
        if (w_done) begin
          if (w_last)                    w_next = S_FULL;
          else if (w_accept && w_legal)  w_next = S_HOLD;
          else                           w_next = S_IDLE;
        end
      end
      S_FULL:  w_next = S_FULL;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && !w_legal;
      if (w_done) begin
        r_addr  <= r_addr + 64'd4;
        r_count <= r_count + 16'd1;
      end
      if (w_accept && w_legal) r_wdata <= w_enc;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.imem_we    = (r_state == S_HOLD);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign err            = r_err;
  assign word_count     = r_count;
  assign full           = (r_state == S_FULL);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus stall, error,
// full, clear and reset sequences, all against hand-computed values.
module tb_instr_encoder_loader;

  localparam logic [63:0] BASE = 64'h100;

  logic        CLK;
  logic        resetl;
  logic        clear;
  logic        err;
  logic [15:0] word_count;
  logic        full;

  instr_encoder_loader_if bus();

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .clear      (clear),
    .bus        (bus),
    .err        (err),
    .word_count (word_count),
    .full       (full)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [1:0]  hw;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw);
    bus.req_op  = op;
    bus.req_rd  = rd;
    bus.req_rn  = rn;
    bus.req_rm  = rm;
    bus.req_imm = imm;
    bus.req_hw  = hw;
  endtask

  task automatic do_clear();
    bus.req_valid = 1'b0;
    clear = 1'b1;
    next_cyc();
    clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'd2,  5'd1,  5'd2,  5'd3, 26'h0,       2'd0, 32'h8B030041}; // ADD
    tbl[1]  = '{4'd0,  5'd1,  5'd2,  5'd3, 26'h0,       2'd0, 32'h8A030041}; // AND
    tbl[2]  = '{4'd1,  5'd1,  5'd2,  5'd3, 26'h0,       2'd0, 32'hAA030041}; // ORR
    tbl[3]  = '{4'd3,  5'd1,  5'd2,  5'd3, 26'h0,       2'd0, 32'hCB030041}; // SUB
    tbl[4]  = '{4'd4,  5'd9,  5'd31, 5'd0, 26'h0FF,     2'd0, 32'h9103FFE9}; // ADDI
    tbl[5]  = '{4'd5,  5'd9,  5'd31, 5'd0, 26'h0FF,     2'd0, 32'hD103FFE9}; // SUBI
    tbl[6]  = '{4'd6,  5'd1,  5'd0,  5'd0, 26'h1234,    2'd3, 32'hD2E24681}; // MOVZ
    tbl[7]  = '{4'd9,  5'd10, 5'd1,  5'd0, 26'd8,       2'd0, 32'hF840802A}; // LDUR
    tbl[8]  = '{4'd10, 5'd10, 5'd1,  5'd0, 26'd8,       2'd0, 32'hF800802A}; // STUR
    tbl[9]  = '{4'd7,  5'd0,  5'd0,  5'd0, 26'h3FFFFFF, 2'd0, 32'h17FFFFFF}; // B
    tbl[10] = '{4'd8,  5'd5,  5'd0,  5'd0, 26'h7FFFE,   2'd0, 32'hB4FFFFC5}; // CBZ
    tbl[11] = '{4'd4,  5'd0,  5'd0,  5'd0, 26'h3FFF123, 2'd0, 32'h91048C00}; // ADDI truncated imm
    tbl[12] = '{4'd9,  5'd0,  5'd0,  5'd0, 26'h3FFFF01, 2'd0, 32'hF8501000}; // LDUR truncated imm

    resetl = 1'b0;
    clear  = 1'b0;
    bus.req_valid   = 1'b0;
    bus.imem_wready = 1'b1;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 26'h0, 2'd0);
    #12;
    chk("rst_we",    64'(bus.imem_we),    64'd0);
    chk("rst_addr",  bus.imem_addr,       BASE);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_err",   64'(err),            64'd0);
    chk("rst_count", 64'(word_count),     64'd0);
    chk("rst_full",  64'(full),           64'd0);
    resetl = 1'b1;
    next_cyc();
    chk("rst_ready", 64'(bus.req_ready),  64'd1);

    // Encoding table: one word per vector from a freshly cleared loader.
    foreach (tbl[i]) begin
      do_clear();
      bus.imem_wready = 1'b1;
      set_req(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, tbl[i].hw);
      bus.req_valid = 1'b1;
      @(negedge CLK);
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'd1);
      next_cyc();
      bus.req_valid = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_we", i),    64'(bus.imem_we),    64'd1);
      chk($sformatf("v%0d_wdata", i), 64'(bus.imem_wdata), 64'(tbl[i].exp));
      chk($sformatf("v%0d_addr", i),  bus.imem_addr,       BASE);
      next_cyc();
      @(negedge CLK);
      chk($sformatf("v%0d_we_off", i), 64'(bus.imem_we),  64'd0);
      chk($sformatf("v%0d_addr4", i),  bus.imem_addr,     BASE + 64'd4);
      chk($sformatf("v%0d_count", i),  64'(word_count),   64'd1);
    end

    // Back-to-back three words, 2nd word stalled two cycles.
    do_clear();
    bus.imem_wready = 1'b1;
    set_req(4'd2, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    bus.req_valid = 1'b1;
    next_cyc();
    set_req(4'd9, 5'd10, 5'd1, 5'd0, 26'd8, 2'd0);
    @(negedge CLK);
    chk("b2b_w0_data", 64'(bus.imem_wdata), 64'h8B030041);
    chk("b2b_w0_addr", bus.imem_addr,       BASE);
    chk("b2b_w0_rdy",  64'(bus.req_ready),  64'd1);
    next_cyc();
    set_req(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0);
    bus.imem_wready = 1'b0;
    for (int unsigned s = 0; s < 2; s++) begin
      @(negedge CLK);
      chk($sformatf("b2b_stall%0d_rdy", s),  64'(bus.req_ready),  64'd0);
      chk($sformatf("b2b_stall%0d_we", s),   64'(bus.imem_we),    64'd1);
      chk($sformatf("b2b_stall%0d_data", s), 64'(bus.imem_wdata), 64'hF840802A);
      chk($sformatf("b2b_stall%0d_addr", s), bus.imem_addr,       BASE + 64'd4);
      chk($sformatf("b2b_stall%0d_cnt", s),  64'(word_count),     64'd1);
      next_cyc();
    end
    bus.imem_wready = 1'b1;
    @(negedge CLK);
    chk("b2b_w1_rdy",  64'(bus.req_ready),  64'd1);
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_w2_data", 64'(bus.imem_wdata), 64'h17FFFFFF);
    chk("b2b_w2_addr", bus.imem_addr,       BASE + 64'd8);
    next_cyc();
    @(negedge CLK);
    chk("b2b_end_we",   64'(bus.imem_we), 64'd0);
    chk("b2b_end_cnt",  64'(word_count),  64'd3);
    chk("b2b_end_addr", bus.imem_addr,    BASE + 64'd12);

    // Illegal op: single err pulse, nothing written.
    do_clear();
    set_req(4'd13, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    bus.req_valid = 1'b1;
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("ill_err",  64'(err),          64'd1);
    chk("ill_we",   64'(bus.imem_we),  64'd0);
    chk("ill_addr", bus.imem_addr,     BASE);
    next_cyc();
    @(negedge CLK);
    chk("ill_err_drop", 64'(err),      64'd0);
    chk("ill_cnt",      64'(word_count), 64'd0);

    // Fill to DEPTH=4, then a held-off request survives a clear.
    set_req(4'd2, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    bus.req_valid = 1'b1;
    for (int unsigned w = 0; w < 4; w++) next_cyc();
    set_req(4'd6, 5'd1, 5'd0, 5'd0, 26'h1234, 2'd3);
    @(negedge CLK);
    chk("fill_last_rdy", 64'(bus.req_ready), 64'd0);
    next_cyc();
    for (int unsigned s = 0; s < 2; s++) begin
      @(negedge CLK);
      chk($sformatf("full%0d_flag", s), 64'(full),          64'd1);
      chk($sformatf("full%0d_rdy", s),  64'(bus.req_ready), 64'd0);
      chk($sformatf("full%0d_we", s),   64'(bus.imem_we),   64'd0);
      chk($sformatf("full%0d_cnt", s),  64'(word_count),    64'd4);
      chk($sformatf("full%0d_addr", s), bus.imem_addr,      BASE + 64'd16);
      next_cyc();
    end
    clear = 1'b1;
    @(negedge CLK);
    chk("fclr_rdy", 64'(bus.req_ready), 64'd0);
    next_cyc();
    clear = 1'b0;
    @(negedge CLK);
    chk("fclr_full", 64'(full),          64'd0);
    chk("fclr_cnt",  64'(word_count),    64'd0);
    chk("fclr_addr", bus.imem_addr,      BASE);
    chk("fclr_rdy2", 64'(bus.req_ready), 64'd1);
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("fclr_held_data", 64'(bus.imem_wdata), 64'hD2E24681);
    chk("fclr_held_we",   64'(bus.imem_we),    64'd1);

    // Clear beats a completion and an accept in the same cycle.
    do_clear();
    bus.imem_wready = 1'b0;
    set_req(4'd3, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    bus.req_valid = 1'b1;
    next_cyc();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    clear = 1'b1;
    bus.imem_wready = 1'b1;
    @(negedge CLK);
    chk("cpri_rdy", 64'(bus.req_ready), 64'd0);
    next_cyc();
    clear = 1'b0;
    @(negedge CLK);
    chk("cpri_we",   64'(bus.imem_we), 64'd0);
    chk("cpri_cnt",  64'(word_count),  64'd0);
    chk("cpri_addr", bus.imem_addr,    BASE);
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("cpri_next_data", 64'(bus.imem_wdata), 64'h8A030041);

    // Async reset while a word is held abandons it.
    do_clear();
    bus.imem_wready = 1'b0;
    set_req(4'd2, 5'd1, 5'd2, 5'd3, 26'h0, 2'd0);
    bus.req_valid = 1'b1;
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("arst_pre_we", 64'(bus.imem_we), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    chk("arst_we",    64'(bus.imem_we),    64'd0);
    chk("arst_addr",  bus.imem_addr,       BASE);
    chk("arst_wdata", 64'(bus.imem_wdata), 64'd0);
    next_cyc();
    resetl = 1'b1;
    bus.imem_wready = 1'b1;
    next_cyc();
    next_cyc();
    @(negedge CLK);
    chk("arst_post_we",  64'(bus.imem_we), 64'd0);
    chk("arst_post_cnt", 64'(word_count),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
